// File: rtl/g4_table_pkg.sv
// Shared definitions for the G4 rule table: entry field positions, sentinels,
// response codes and the insert FSM state encoding.
package g4_table_pkg;

  localparam int IDX_W   = 11;
  localparam int RULE_W  = 149;
  localparam int ENTRY_W = 171;

  // Match-field positions inside an entry (bits 37:32 and 75:70 are unused).
  localparam int SRC_IP_LSB     = 0;
  localparam int DST_IP_LSB     = 38;
  localparam int SRC_PORT_LSB   = 76;
  localparam int DST_PORT_LSB   = 108;
  localparam int PROTO_LSB      = 140;
  localparam int PROTO_WILD_BIT = 148;
  localparam int ID_LSB         = 149;
  localparam int ID_MSB         = 159;
  localparam int NEXT_LSB       = 160;
  localparam int NEXT_MSB       = 170;

  localparam logic [IDX_W-1:0] NULL_IDX = 11'h7FF;
  localparam logic [IDX_W-1:0] EMPTY_ID = 11'h7FF;

  typedef enum logic [1:0] {
    ST_INSERTED   = 2'b00,
    ST_REPLACED   = 2'b01,
    ST_FULL       = 2'b10,
    ST_CHAIN_LONG = 2'b11
  } status_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    CHECK     = 3'd2,
    WRITE_NEW = 3'd3,
    LINK_TAIL = 3'd4,
    RESP      = 3'd5
  } state_t;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic [IDX_W-1:0] next,
                                                    input logic [IDX_W-1:0] id,
                                                    input logic [RULE_W-1:0] rule);
    return {next, id, rule};
  endfunction

endpackage

// File: rtl/insert_g4_other_rule_if.sv
// Request/response and table-port bundle for the G4 insert block.
interface insert_g4_other_rule_if;
  import g4_table_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [IDX_W-1:0]    req_head;
  logic [RULE_W-1:0]   req_rule;
  logic [IDX_W-1:0]    req_ruleID;
  logic [IDX_W-1:0]    tbl_addr;
  logic                tbl_we;
  logic [ENTRY_W-1:0]  tbl_din;
  logic [ENTRY_W-1:0]  tbl_rdata;
  logic                resp_valid;
  logic [1:0]          resp_status;
  logic [IDX_W-1:0]    resp_index;
  logic [IDX_W-1:0]    free_count;

  // Requester side: issues inserts and owns the table memory.
  modport master (
    output req_valid, req_head, req_rule, req_ruleID, tbl_rdata,
    input  req_ready, tbl_addr, tbl_we, tbl_din, resp_valid, resp_status,
           resp_index, free_count
  );

  // Insert engine side.
  modport slave (
    input  req_valid, req_head, req_rule, req_ruleID, tbl_rdata,
    output req_ready, tbl_addr, tbl_we, tbl_din, resp_valid, resp_status,
           resp_index, free_count
  );

endinterface

// File: rtl/g4_free_alloc.sv
// Bump allocator for the overflow region: hands out FREE_BASE upward until the
// table top is passed, and reports how many slots remain.
module g4_free_alloc
  import g4_table_pkg::*;
#(
  parameter int TABLE_ENTRY_SIZE = 1023,
  parameter int FREE_BASE        = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  output logic [IDX_W-1:0] alloc_idx,
  output logic [IDX_W-1:0] free_count,
  output logic             full
);

  // One extra bit so the pointer can sit one past the last table index.
  localparam logic [IDX_W:0] LIMIT = (IDX_W+1)'(TABLE_ENTRY_SIZE + 1);

  logic [IDX_W:0] free_ptr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      free_ptr_reg <= (IDX_W+1)'(FREE_BASE);
    end else if (alloc && !full) begin
      free_ptr_reg <= free_ptr_reg + (IDX_W+1)'(1);
    end
  end

  assign full       = (free_ptr_reg >= LIMIT);
  assign alloc_idx  = free_ptr_reg[IDX_W-1:0];
  assign free_count = full ? '0 : IDX_W'(LIMIT - free_ptr_reg);

endmodule

// File: rtl/insert_g4_other_rule.sv
// Hash-chain insert engine: walks a bucket chain, replaces a matching rule ID,
// fills an empty head, or appends a new overflow entry and links it to the tail.
module insert_g4_other_rule
  import g4_table_pkg::*;
#(
  parameter int TABLE_ENTRY_SIZE = 1023,
  parameter int FREE_BASE        = 512,
  parameter int MAX_HOPS         = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [IDX_W-1:0]    req_head,
  input  logic [RULE_W-1:0]   req_rule,
  input  logic [IDX_W-1:0]    req_ruleID,
  output logic [IDX_W-1:0]    tbl_addr,
  output logic                tbl_we,
  output logic [ENTRY_W-1:0]  tbl_din,
  input  logic [ENTRY_W-1:0]  tbl_rdata,
  output logic                resp_valid,
  output logic [1:0]          resp_status,
  output logic [IDX_W-1:0]    resp_index,
  output logic [IDX_W-1:0]    free_count
);

  localparam int HOP_W = $clog2(MAX_HOPS + 1);

  state_t              state_reg;
  logic [IDX_W-1:0]    cur_reg;
  logic [HOP_W-1:0]    hops_reg;
  logic [HOP_W-1:0]    hops_inc;
  logic [RULE_W-1:0]   rule_reg;
  logic [IDX_W-1:0]    id_reg;
  logic                append_reg;
  logic [ID_MSB:0]     tail_keep_reg;
  logic                req_ready_reg;
  logic [IDX_W-1:0]    tbl_addr_reg;
  logic                tbl_we_reg;
  logic [ENTRY_W-1:0]  tbl_din_reg;
  logic                resp_valid_reg;
  status_t             resp_status_reg;
  logic [IDX_W-1:0]    resp_index_reg;

  logic [IDX_W-1:0]    rd_id;
  logic [IDX_W-1:0]    rd_next;
  logic                alloc;
  logic [IDX_W-1:0]    alloc_idx;
  logic                alloc_full;

  assign rd_id    = tbl_rdata[ID_MSB:ID_LSB];
  assign rd_next  = tbl_rdata[NEXT_MSB:NEXT_LSB];
  assign hops_inc = hops_reg + HOP_W'(1);
  assign alloc    = (state_reg == LINK_TAIL);

  g4_free_alloc #(
    .TABLE_ENTRY_SIZE (TABLE_ENTRY_SIZE),
    .FREE_BASE        (FREE_BASE)
  ) u_free_alloc (
    .clk        (clk),
    .rst        (rst),
    .alloc      (alloc),
    .alloc_idx  (alloc_idx),
    .free_count (free_count),
    .full       (alloc_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cur_reg         <= '0;
      hops_reg        <= '0;
      rule_reg        <= '0;
      id_reg          <= '0;
      append_reg      <= 1'b0;
      tail_keep_reg   <= '0;
      req_ready_reg   <= 1'b1;
      tbl_addr_reg    <= '0;
      tbl_we_reg      <= 1'b0;
      tbl_din_reg     <= '0;
      resp_valid_reg  <= 1'b0;
      resp_status_reg <= ST_INSERTED;
      resp_index_reg  <= NULL_IDX;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            rule_reg      <= req_rule;
            id_reg        <= req_ruleID;
            cur_reg       <= req_head;
            tbl_addr_reg  <= req_head;
            hops_reg      <= '0;
            append_reg    <= 1'b0;
            req_ready_reg <= 1'b0;
            state_reg     <= READ;
          end
        end

        READ: state_reg <= CHECK;

        CHECK: begin
          if (rd_id == EMPTY_ID) begin
            tbl_we_reg      <= 1'b1;
            tbl_din_reg     <= make_entry(NULL_IDX, id_reg, rule_reg);
            resp_status_reg <= ST_INSERTED;
            state_reg       <= WRITE_NEW;
          end else if (rd_id == id_reg) begin
            tbl_we_reg      <= 1'b1;
            tbl_din_reg     <= make_entry(rd_next, id_reg, rule_reg);
            resp_status_reg <= ST_REPLACED;
            state_reg       <= WRITE_NEW;
          end else if (rd_next != NULL_IDX) begin
            hops_reg <= hops_inc;
            if (hops_inc == HOP_W'(MAX_HOPS)) begin
              resp_status_reg <= ST_CHAIN_LONG;
              resp_index_reg  <= NULL_IDX;
              resp_valid_reg  <= 1'b1;
              state_reg       <= RESP;
            end else begin
              cur_reg      <= rd_next;
              tbl_addr_reg <= rd_next;
              state_reg    <= READ;
            end
          end else if (alloc_full) begin
            resp_status_reg <= ST_FULL;
            resp_index_reg  <= NULL_IDX;
            resp_valid_reg  <= 1'b1;
            state_reg       <= RESP;
          end else begin
            // New entry goes out first; the tail keeps its contents for the link write.
            append_reg      <= 1'b1;
            tail_keep_reg   <= tbl_rdata[ID_MSB:0];
            tbl_addr_reg    <= alloc_idx;
            tbl_we_reg      <= 1'b1;
            tbl_din_reg     <= make_entry(NULL_IDX, id_reg, rule_reg);
            resp_status_reg <= ST_INSERTED;
            state_reg       <= WRITE_NEW;
          end
        end

        WRITE_NEW: begin
          tbl_addr_reg <= cur_reg;
          if (append_reg) begin
            tbl_din_reg <= {alloc_idx, tail_keep_reg};
            state_reg   <= LINK_TAIL;
          end else begin
            tbl_we_reg     <= 1'b0;
            resp_index_reg <= cur_reg;
            resp_valid_reg <= 1'b1;
            state_reg      <= RESP;
          end
        end

        LINK_TAIL: begin
          tbl_we_reg     <= 1'b0;
          resp_index_reg <= alloc_idx;
          resp_valid_reg <= 1'b1;
          state_reg      <= RESP;
        end

        RESP: begin
          resp_valid_reg <= 1'b0;
          req_ready_reg  <= 1'b1;
          state_reg      <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  // Gate the strobe with reset so an abort lands before the pending write.
  assign tbl_we      = tbl_we_reg & ~rst;
  assign tbl_addr    = tbl_addr_reg;
  assign tbl_din     = tbl_din_reg;
  assign req_ready   = req_ready_reg;
  assign resp_valid  = resp_valid_reg;
  assign resp_status = resp_status_reg;
  assign resp_index  = resp_index_reg;

endmodule

// File: tb/tb_insert_g4_other_rule.sv
// Directed bench for insert_g4_other_rule with a registered-read table model.
module tb_insert_g4_other_rule;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  insert_g4_other_rule_if bus();

  insert_g4_other_rule dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (bus.req_valid),
    .req_ready   (bus.req_ready),
    .req_head    (bus.req_head),
    .req_rule    (bus.req_rule),
    .req_ruleID  (bus.req_ruleID),
    .tbl_addr    (bus.tbl_addr),
    .tbl_we      (bus.tbl_we),
    .tbl_din     (bus.tbl_din),
    .tbl_rdata   (bus.tbl_rdata),
    .resp_valid  (bus.resp_valid),
    .resp_status (bus.resp_status),
    .resp_index  (bus.resp_index),
    .free_count  (bus.free_count)
  );

  // Table model: one-cycle registered read, plus a bench-side preload port.
  logic [170:0] mem [0:2047];
  logic         tb_clear;
  logic         tb_we;
  logic [10:0]  tb_addr;
  logic [170:0] tb_data;
  int           wr_cnt;
  logic [10:0]  log_addr [0:4095];
  logic [170:0] log_data [0:4095];

  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 2048; i++) mem[i] <= '1;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end
    if (bus.tbl_we) begin
      mem[bus.tbl_addr]       <= bus.tbl_din;
      log_addr[wr_cnt % 4096] <= bus.tbl_addr;
      log_data[wr_cnt % 4096] <= bus.tbl_din;
      wr_cnt                  <= wr_cnt + 1;
    end
    bus.tbl_rdata <= mem[bus.tbl_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [170:0] got, input logic [170:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [148:0] mk_rule(input logic [7:0] proto, input logic [31:0] sip,
                                           input logic [31:0] dip, input logic [15:0] port);
    return {1'b0, proto, port, ~port, port ^ 16'h00FF, port + 16'd1, 6'd0, dip, 6'd0, sip};
  endfunction

  task automatic mem_put(input logic [10:0] a, input logic [170:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic do_insert(input logic [10:0] head, input logic [148:0] rule, input logic [10:0] id,
                           output logic [1:0] st, output logic [10:0] idx,
                           output int lat, output int nwr, output int w0);
    bit got;
    @(negedge clk);
    bus.req_head = head; bus.req_rule = rule; bus.req_ruleID = id; bus.req_valid = 1'b1;
    w0 = wr_cnt;
    check("ready_before_accept", {170'd0, bus.req_ready}, 171'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0; got = 0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.resp_valid) got = 1;
    end
    check("resp_seen", {170'd0, got}, 171'd1);
    st = bus.resp_status; idx = bus.resp_index; nwr = wr_cnt - w0;
    $display("insert head=%0d id=%0h -> status=%0d index=%0h latency=%0d writes=%0d free=%0d",
             head, id, st, idx, lat, nwr, bus.free_count);
  endtask

  logic [148:0] rule_a, rule_b, rule_c;
  logic [1:0]   st;
  logic [10:0]  idx;
  int           lat, nwr, w0;
  bit           saw_resp;
  bit           hit;

  initial begin
    rule_a = mk_rule(8'd6,  32'hC0A80001, 32'h0A000001, 16'd80);
    rule_b = mk_rule(8'd17, 32'hAC100005, 32'h08080808, 16'd53);
    rule_c = mk_rule(8'd1,  32'h7F000001, 32'hFFFFFFFF, 16'd443);
    bus.req_valid = 1'b0; bus.req_head = '0; bus.req_rule = '0; bus.req_ruleID = '0;
    tb_we = 1'b0; tb_addr = '0; tb_data = '0; wr_cnt = 0;
    rst = 1'b1; tb_clear = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",  {170'd0, bus.req_ready},  171'd1);
    check("rst_valid",  {170'd0, bus.resp_valid}, 171'd0);
    check("rst_we",     {170'd0, bus.tbl_we},     171'd0);
    check("rst_status", {169'd0, bus.resp_status}, 171'd0);
    check("rst_index",  {160'd0, bus.resp_index}, 171'h7FF);
    check("rst_free",   {160'd0, bus.free_count}, 171'd512);
    rst = 1'b0; tb_clear = 1'b0;

    // Empty head 5
    do_insert(11'd5, rule_a, 11'd3, st, idx, lat, nwr, w0);
    check("empty_status", {169'd0, st}, 171'd0);
    check("empty_index",  {160'd0, idx}, 171'd5);
    check("empty_lat",    171'(lat), 171'd4);
    check("empty_nwr",    171'(nwr), 171'd1);
    check("empty_waddr",  {160'd0, log_addr[w0 % 4096]}, 171'd5);
    check("empty_wdata",  log_data[w0 % 4096], {11'h7FF, 11'd3, rule_a});
    check("resp_busy_ready", {170'd0, bus.req_ready}, 171'd0);
    @(negedge clk);
    check("resp_pulse_end", {170'd0, bus.resp_valid}, 171'd0);
    check("ready_back",     {170'd0, bus.req_ready},  171'd1);

    // First append at head 5 -> overflow slot 512
    do_insert(11'd5, rule_b, 11'd7, st, idx, lat, nwr, w0);
    check("app1_status", {169'd0, st}, 171'd0);
    check("app1_index",  {160'd0, idx}, 171'd512);
    check("app1_lat",    171'(lat), 171'd5);
    check("app1_free",   {160'd0, bus.free_count}, 171'd511);

    // Chain 5->512, append ID 9 at 513, link tail 512
    do_insert(11'd5, rule_c, 11'd9, st, idx, lat, nwr, w0);
    check("app2_status", {169'd0, st}, 171'd0);
    check("app2_index",  {160'd0, idx}, 171'd513);
    check("app2_lat",    171'(lat), 171'd7);
    check("app2_nwr",    171'(nwr), 171'd2);
    check("app2_new_addr", {160'd0, log_addr[w0 % 4096]}, 171'd513);
    check("app2_new_data", log_data[w0 % 4096], {11'h7FF, 11'd9, rule_c});
    check("app2_link_addr", {160'd0, log_addr[(w0 + 1) % 4096]}, 171'd512);
    check("app2_link_data", log_data[(w0 + 1) % 4096], {11'd513, 11'd7, rule_b});
    check("app2_free",   {160'd0, bus.free_count}, 171'd510);

    // Replace ID 3 at head 5; next (512) must survive
    do_insert(11'd5, rule_b, 11'd3, st, idx, lat, nwr, w0);
    check("repl_status", {169'd0, st}, 171'd1);
    check("repl_index",  {160'd0, idx}, 171'd5);
    check("repl_nwr",    171'(nwr), 171'd1);
    check("repl_data",   log_data[w0 % 4096], {11'd512, 11'd3, rule_b});
    check("repl_free",   {160'd0, bus.free_count}, 171'd510);

    // 16-entry circular chain 100..115
    for (int i = 0; i < 16; i++)
      mem_put(11'(100 + i), {11'(100 + ((i + 1) % 16)), 11'(200 + i), rule_a});
    do_insert(11'd100, rule_a, 11'd50, st, idx, lat, nwr, w0);
    check("loop_status", {169'd0, st}, 171'd3);
    check("loop_index",  {160'd0, idx}, 171'h7FF);
    check("loop_nwr",    171'(nwr), 171'd0);
    check("loop_lat",    171'(lat), 171'd33);

    // Reset during LINK_TAIL of append at 514 behind tail 513
    @(negedge clk);
    bus.req_head = 11'd5; bus.req_rule = rule_a; bus.req_ruleID = 11'd11; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      if (bus.tbl_we && bus.tbl_addr == 11'd513) hit = 1;
    end
    check("abort_link_seen", {170'd0, hit}, 171'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", {170'd0, bus.req_ready},  171'd1);
    check("abort_valid", {170'd0, bus.resp_valid}, 171'd0);
    check("abort_free",  {160'd0, bus.free_count}, 171'd512);
    rst = 1'b0;
    saw_resp = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.resp_valid) saw_resp = 1;
    end
    check("abort_no_resp", {170'd0, saw_resp}, 171'd0);
    check("abort_tail_next", {160'd0, mem[513][170:160]}, 171'h7FF);
    check("abort_new_id",    {160'd0, mem[514][159:149]}, 171'd11);
    $display("abort in LINK_TAIL: tail next=%0h free=%0d", mem[513][170:160], bus.free_count);

    // Fill overflow region: heads 0..511 each get one appended entry
    @(negedge clk); tb_clear = 1'b1;
    @(negedge clk); tb_clear = 1'b0;
    for (int i = 0; i < 512; i++) mem_put(11'(i), {11'h7FF, 11'(i), rule_b});
    for (int i = 0; i < 512; i++) begin
      do_insert(11'(i), rule_c, 11'h600, st, idx, lat, nwr, w0);
      check("fill_status", {169'd0, st}, 171'd0);
      check("fill_index",  {160'd0, idx}, 171'(512 + i));
    end
    check("fill_free", {160'd0, bus.free_count}, 171'd0);

    do_insert(11'd20, rule_a, 11'h601, st, idx, lat, nwr, w0);
    check("full_status", {169'd0, st}, 171'd2);
    check("full_index",  {160'd0, idx}, 171'h7FF);
    check("full_nwr",    171'(nwr), 171'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
